// File: rtl/dff_share_arbiter_if.sv
// Bundle of the requester-facing and register-facing signals of the
// shared-register arbiter.
//   req      requester -> arbiter  per-requester level request
//   wdata    requester -> arbiter  packed write data, requester i at [i*WIDTH +: WIDTH]
//   grant    arbiter -> requester  registered one-hot grant
//   owner    arbiter -> requester  index of current/last granted requester
//   q        arbiter -> consumer   shared register contents
//   q_valid  arbiter -> consumer   q written at least once since reset
//   busy     arbiter -> requester  a grant is active
interface dff_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int OW    = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       grant;
  logic [OW-1:0]         owner;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic                  busy;

  modport master (
    output req, wdata,
    input  grant, owner, q, q_valid, busy
  );

  modport slave (
    input  req, wdata,
    output grant, owner, q, q_valid, busy
  );
endinterface

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit register among NREQ
// requesters. The granted owner's wdata slice is clocked into q every cycle
// it keeps req high, for at most MAX_HOLD writes per grant; every release
// passes through one IDLE cycle and moves the round-robin pointer past the
// released owner.
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    slave side of dff_share_arbiter_if (req/wdata in; grant, owner,
//          q, q_valid, busy out)
//
// state  | meaning
// IDLE   | no grant; arbitrate among req starting at ptr
// BUSY   | grant held; owner's wdata written while req[owner] is high
module dff_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  parameter int OW       = 2
) (
  input  logic           clk,
  input  logic           reset,
  dff_share_arbiter_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // Remaining writes after the current one; release on reaching zero.
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [0:0]       state;
  logic [NREQ-1:0]  grant_r;
  logic [OW-1:0]    owner_r;
  logic [OW-1:0]    ptr;
  logic [HW-1:0]    hold_left;
  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;
  logic             busy_r;

  logic             found;
  logic [OW-1:0]    winner;
  int               idx;
  logic [OW-1:0]    ptr_next;
  logic [WIDTH-1:0] owner_wdata;
  logic             owner_req;

  // First requester at or above ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

  assign ptr_next    = (owner_r == OW'(NREQ - 1)) ? '0 : owner_r + 1'b1;
  assign owner_wdata = bus.wdata[int'(owner_r)*WIDTH +: WIDTH];
  assign owner_req   = bus.req[owner_r];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      grant_r   <= '0;
      owner_r   <= '0;
      ptr       <= '0;
      hold_left <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_r   <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
            owner_r   <= winner;
            hold_left <= HW'(MAX_HOLD - 1);
            busy_r    <= 1'b1;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (owner_req) begin
            q_r       <= owner_wdata;
            q_valid_r <= 1'b1;
          end
          if (owner_req && (hold_left != '0)) begin
            hold_left <= hold_left - 1'b1;
          end else begin
            grant_r <= '0;
            busy_r  <= 1'b0;
            ptr     <= ptr_next;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant   = grant_r;
  assign bus.owner   = owner_r;
  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.busy    = busy_r;

endmodule
